generic_rom_mp: RTL and testbench
=================================

GENERIC_ROM_MP -- requirements
Module: generic_rom_mp

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 10, meaning request address width in words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning read word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDRESS_WIDTH, meaning number of implemented words; legal range 1..2**ADDRESS_WIDTH.
REQ-004 The block SHALL have parameter NUM_PORTS, default 2, meaning number of independent read ports; legal range 1..8.
REQ-005 The block SHALL have parameter READ_LATENCY, default 1, meaning request-to-response cycles; legal range 1..4.
REQ-006 The block SHALL have parameter INIT_FILE, default "", meaning hex image loaded by $readmemh at time zero; empty means contents are X.
REQ-007 Port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-008 Port i_rst  input  1  reset, synchronous, active-high.
REQ-009 Port i_req_valid  input  NUM_PORTS  per-port request valid.
REQ-010 Port o_req_ready  output  NUM_PORTS  per-port request accept.
REQ-011 Port i_req_address  input  NUM_PORTS*ADDRESS_WIDTH  per-port address; port p at bits [p*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-012 Port o_rsp_valid  output  NUM_PORTS  per-port response valid.
REQ-013 Port i_rsp_ready  input  NUM_PORTS  per-port response accept.
REQ-014 Port o_rsp_data  output  NUM_PORTS*DATA_WIDTH  per-port read data, packed as REQ-011.
REQ-015 Port o_rsp_error  output  NUM_PORTS  per-port out-of-range flag (see Configuration).

Function
REQ-016 Ports SHALL be fully independent: shared read-only array, no arbitration, no cross-port stalls.
REQ-017 Request on port p SHALL be accepted on a rising edge where i_req_valid[p] and o_req_ready[p] are both 1.
REQ-018 Each port SHALL hold a READ_LATENCY-stage pipeline of {valid, data, error}; stage 0 captures rom[address] at accept.
REQ-019 Port pipeline SHALL advance when advance[p] = !o_rsp_valid[p] | i_rsp_ready[p]; otherwise all stages hold.
REQ-020 o_req_ready[p] SHALL equal advance[p] (combinational from i_rsp_ready and final-stage valid).
REQ-021 With no backpressure, a request accepted at edge N SHALL present o_rsp_valid at edge N+READ_LATENCY-1 output, i.e. visible for the cycle after edge N+READ_LATENCY-1; sustained throughput one response per cycle per port.
REQ-022 Responses SHALL return in request order per port; bubbles are not collapsed during a stall.
REQ-023 o_rsp_data and o_rsp_error SHALL remain stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-024 Accept with i_rsp_ready=1 on a full pipeline SHALL retire final stage and enter new request on the same edge (no lost or duplicated beat).
REQ-025 Two ports reading the same address on the same edge SHALL both return the same word.

Reset
REQ-026 On an edge with i_rst=1 all pipeline valid bits, o_rsp_valid, o_rsp_data and o_rsp_error SHALL become 0; in-flight requests are discarded.
REQ-027 o_req_ready SHALL be 1 on the cycle after reset (pipeline empty).
REQ-028 Reset SHALL NOT alter ROM contents; a request presented with i_rst=1 SHALL NOT be accepted.

Configuration
REQ-029 Macro GENERIC_ROM_MP_BOUNDS_CHECK_EN defined: address >= DEPTH SHALL return data 0 with o_rsp_error=1; in-range SHALL return error 0.
REQ-030 Macro undefined: bounds logic SHALL be absent, o_rsp_error tied 0, out-of-range read data undefined.

Structure
REQ-031 Shared package generic_rom_pkg SHALL hold READ_LATENCY min/max, NUM_PORTS max, and the response-stage record layout.
REQ-032 Per-port pipeline SHALL be sub-module generic_rom_mp_port, instantiated NUM_PORTS times by generate loop; array and $readmemh stay in the top.

Verification
REQ-033 Image rom[k]=k*3, READ_LATENCY=2, port 0 streams addresses 0..7 with i_rsp_ready=1 -> data 0,3,...,21 on 8 consecutive cycles, first two cycles after first accept.
REQ-034 Port 0 reads 5, i_rsp_ready=0 for 4 cycles -> o_rsp_data=15 stable, o_req_ready[0]=0 after pipeline fills; release -> remaining beats in order.
REQ-035 NUM_PORTS=4, all ports read address 9 same edge -> all four return 27 same cycle; port 1 stalled does not delay ports 0,2,3.
REQ-036 DEPTH=100, macro defined, read address 100 -> data 0, error 1; address 99 -> 297, error 0; macro undefined -> error always 0.
REQ-037 Reset asserted with 2 beats in flight -> next cycle o_rsp_valid=0, data=0, o_req_ready=1; no stale beat after release.
REQ-038 Random valid/ready on each port, READ_LATENCY 1..4, 10k requests -> scoreboard matches image, order preserved, zero drops or duplicates.

Source files
------------

// File: rtl/generic_rom_pkg.sv
// generic_rom_pkg
//   Shared definitions for the multi-port ROM: legal parameter ranges and the
//   layout of one response-pipeline stage.
//
//   A stage record is { ctl : rsp_ctl_t, data : logic [DATA_WIDTH-1:0] }.
//   The control part is fixed-width and lives here. The data part depends on
//   the instance DATA_WIDTH, so each port module builds its own stage_t from
//   rsp_ctl_t. rsp_stage_w() gives the packed width of the full record.
package generic_rom_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;
  localparam int NUM_PORTS_MAX    = 8;

  // Control fields carried alongside the read word through every stage.
  typedef struct packed {
    logic valid;
    logic error;
  } rsp_ctl_t;

  localparam int RSP_CTL_W = $bits(rsp_ctl_t);

  function automatic int rsp_stage_w(input int data_w);
    return data_w + RSP_CTL_W;
  endfunction

endpackage

// File: rtl/generic_rom_mp_port.sv
// generic_rom_mp_port
//   One independent read port: a READ_LATENCY-deep pipeline of
//   {valid, error, data} records with valid/ready flow control on both sides.
//   The ROM read itself happens in the top; this block only registers the
//   word presented on i_rd_data / i_rd_error at accept time.
//
//   Ports
//     i_clk, i_rst       clock, synchronous active-high reset
//     i_req_valid        request valid for this port
//     o_req_ready        request accept (== pipeline advance)
//     i_rd_data          rom[address] for the current request
//     i_rd_error         out-of-range flag for the current request
//     o_rsp_valid        final-stage valid
//     i_rsp_ready        downstream accept
//     o_rsp_data         final-stage data
//     o_rsp_error        final-stage error flag
module generic_rom_mp_port
  import generic_rom_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_error,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_error
);

  typedef struct packed {
    rsp_ctl_t              ctl;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  localparam int LAST = READ_LATENCY - 1;

  stage_t stg [READ_LATENCY];
  logic   advance;

  // The whole pipe moves as one unit: either every stage shifts or every
  // stage holds. Bubbles therefore keep their slot during a stall, and the
  // final stage can retire on the same edge a new request enters stage 0.
  assign advance     = !stg[LAST].ctl.valid | i_rsp_ready;
  assign o_req_ready = advance;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else if (advance) begin
      // Bubbles carry zero payload so idle outputs do not show stray ROM data.
      stg[0].ctl.valid <= i_req_valid;
      stg[0].ctl.error <= i_req_valid & i_rd_error;
      stg[0].data      <= i_req_valid ? i_rd_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign o_rsp_valid = stg[LAST].ctl.valid;
  assign o_rsp_error = stg[LAST].ctl.error;
  assign o_rsp_data  = stg[LAST].data;

endmodule

// File: rtl/generic_rom_mp.sv
// generic_rom_mp
//   Read-only memory with NUM_PORTS fully independent read ports. All ports
//   share one array; there is no arbitration and a stall on one port never
//   affects another. Each port has a READ_LATENCY-stage response pipeline.
//
//   Optional feature (macro GENERIC_ROM_MP_BOUNDS_CHECK_EN):
//     defined   -> address >= DEPTH returns data 0 and o_rsp_error = 1
//     undefined -> no bounds logic, o_rsp_error tied 0, out-of-range data
//                  is undefined
//
//   Ports
//     i_clk          sole clock, rising edge
//     i_rst          synchronous active-high reset (pipelines only, not ROM)
//     i_req_valid    [NUM_PORTS]                  request valid
//     o_req_ready    [NUM_PORTS]                  request accept
//     i_req_address  [NUM_PORTS*ADDRESS_WIDTH]    port p at p*ADDRESS_WIDTH
//     o_rsp_valid    [NUM_PORTS]                  response valid
//     i_rsp_ready    [NUM_PORTS]                  response accept
//     o_rsp_data     [NUM_PORTS*DATA_WIDTH]       port p at p*DATA_WIDTH
//     o_rsp_error    [NUM_PORTS]                  out-of-range flag
module generic_rom_mp
  import generic_rom_pkg::*;
#(
  parameter int    ADDRESS_WIDTH = 10,
  parameter int    DATA_WIDTH    = 32,
  parameter int    DEPTH         = 2**ADDRESS_WIDTH,
  parameter int    NUM_PORTS     = 2,
  parameter int    READ_LATENCY  = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_PORTS-1:0]            i_req_valid,
  output logic [NUM_PORTS-1:0]            o_req_ready,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_req_address,
  output logic [NUM_PORTS-1:0]            o_rsp_valid,
  input  logic [NUM_PORTS-1:0]            i_rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_rsp_data,
  output logic [NUM_PORTS-1:0]            o_rsp_error
);

  // Index width for the implemented words only; upper address bits are
  // looked at solely by the bounds check.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_rl
    $error("generic_rom_mp: READ_LATENCY out of range");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > NUM_PORTS_MAX) begin : g_bad_np
    $error("generic_rom_mp: NUM_PORTS out of range");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDRESS_WIDTH) begin : g_bad_depth
    $error("generic_rom_mp: DEPTH out of range");
  end

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_error;

    assign addr = i_req_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];

`ifdef GENERIC_ROM_MP_BOUNDS_CHECK_EN
    // One extra bit so DEPTH == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(DEPTH);
    logic in_range;
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign rd_data  = in_range ? rom[addr[IDX_W-1:0]] : '0;
    assign rd_error = !in_range;
`else
    // Upper bits beyond the implemented depth are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^addr;
    assign rd_data  = rom[addr[IDX_W-1:0]];
    assign rd_error = 1'b0;
`endif

    generic_rom_mp_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_port (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid[p]),
      .o_req_ready (o_req_ready[p]),
      .i_rd_data   (rd_data),
      .i_rd_error  (rd_error),
      .o_rsp_valid (o_rsp_valid[p]),
      .i_rsp_ready (i_rsp_ready[p]),
      .o_rsp_data  (o_rsp_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_rsp_error (o_rsp_error[p])
    );
  end

endmodule

// File: tb/tb_generic_rom_mp.sv
// Bench for generic_rom_mp. Image rom[k] = k*3 is written into each instance
// at time zero. Instance u_a: 4 ports, DEPTH 100, READ_LATENCY 2 (directed
// tests). Instances g_rnd[g].u_r: 2 ports, DEPTH 64, READ_LATENCY g+1
// (random traffic with a per-port scoreboard).
module tb_generic_rom_mp;

  localparam int RN    = 4;
  localparam int RND_N = 1250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Directed-test instance
  logic [3:0]   a_rv, a_ry, a_rr, a_ov, a_oe;
  logic [39:0]  a_addr;
  logic [127:0] a_od;

  generic_rom_mp #(
    .ADDRESS_WIDTH(10), .DATA_WIDTH(32), .DEPTH(100),
    .NUM_PORTS(4), .READ_LATENCY(2), .INIT_FILE("")
  ) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(a_rv), .o_req_ready(a_rr), .i_req_address(a_addr),
    .o_rsp_valid(a_ov), .i_rsp_ready(a_ry), .o_rsp_data(a_od), .o_rsp_error(a_oe)
  );

  initial for (int k = 0; k < 100; k++) u_a.rom[k] = 32'(k*3);

  // Random-test instances, one per latency
  logic [1:0]  r_rv   [RN];
  logic [1:0]  r_ry   [RN];
  logic [11:0] r_addr [RN];
  logic [1:0]  r_rr   [RN];
  logic [1:0]  r_ov   [RN];
  logic [1:0]  r_oe   [RN];
  logic [31:0] r_od   [RN];

  for (genvar g = 0; g < RN; g++) begin : g_rnd
    generic_rom_mp #(
      .ADDRESS_WIDTH(6), .DATA_WIDTH(16), .DEPTH(64),
      .NUM_PORTS(2), .READ_LATENCY(g+1), .INIT_FILE("")
    ) u_r (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(r_rv[g]), .o_req_ready(r_rr[g]), .i_req_address(r_addr[g]),
      .o_rsp_valid(r_ov[g]), .i_rsp_ready(r_ry[g]), .o_rsp_data(r_od[g]), .o_rsp_error(r_oe[g])
    );
    initial for (int k = 0; k < 64; k++) u_r.rom[k] = 16'(k*3);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_rv = '0; a_ry = '0; a_addr = '0;
    for (int g = 0; g < RN; g++) begin r_rv[g] = '0; r_ry[g] = '0; r_addr[g] = '0; end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_total++; if (a_ov !== 4'h0) $display("FAIL reset_rsp_valid got=%h exp=0", a_ov); else n_pass++;
    n_total++; if (a_od !== '0) $display("FAIL reset_rsp_data got=%h exp=0", a_od); else n_pass++;
    n_total++; if (a_oe !== 4'h0) $display("FAIL reset_rsp_error got=%h exp=0", a_oe); else n_pass++;
    n_total++; if (a_rr !== 4'hF) $display("FAIL reset_req_ready got=%h exp=f", a_rr); else n_pass++;
    n_total++; if (r_ov[3] !== 2'b00) $display("FAIL reset_rnd_valid got=%b exp=00", r_ov[3]); else n_pass++;
  endtask

  // Port 0 streams addresses 0..7, no backpressure.
  task automatic test_stream();
    int nb = 0;
    a_ry = 4'hF; a_rv = 4'b0001; a_addr = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c < 7) a_addr[9:0] = 10'(c+1); else a_rv[0] = 1'b0;
      if (a_ov[0]) begin
        n_total++;
        if (a_od[31:0] !== 32'(nb*3) || c != nb+1)
          $display("FAIL stream_beat%0d got=%0d@cyc%0d exp=%0d@cyc%0d", nb, a_od[31:0], c, nb*3, nb+1);
        else n_pass++;
        nb++;
      end
    end
    n_total++; if (nb != 8) $display("FAIL stream_count got=%0d exp=8", nb); else n_pass++;
  endtask

  // Port 0 reads 5,6,7 with the response side stalled for a while.
  task automatic test_backpressure();
    a_ry = 4'hE; a_rv = 4'b0001; a_addr[9:0] = 10'd5;
    tick(); a_addr[9:0] = 10'd6;
    tick(); a_addr[9:0] = 10'd7;
    #1;
    n_total++;
    if (a_ov[0] !== 1'b1 || a_od[31:0] !== 32'd15 || a_rr[0] !== 1'b0)
      $display("FAIL bp_fill got v=%b d=%0d rdy=%b exp v=1 d=15 rdy=0", a_ov[0], a_od[31:0], a_rr[0]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (a_ov[0] !== 1'b1 || a_od[31:0] !== 32'd15 || a_rr[0] !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b d=%0d rdy=%b exp v=1 d=15 rdy=0", i, a_ov[0], a_od[31:0], a_rr[0]);
      else n_pass++;
    end
    a_ry[0] = 1'b1;
    #1;
    n_total++; if (a_rr[0] !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", a_rr[0]); else n_pass++;
    tick(); a_rv[0] = 1'b0;
    n_total++;
    if (a_ov[0] !== 1'b1 || a_od[31:0] !== 32'd18) $display("FAIL bp_beat6 got v=%b d=%0d exp v=1 d=18", a_ov[0], a_od[31:0]);
    else n_pass++;
    tick();
    n_total++;
    if (a_ov[0] !== 1'b1 || a_od[31:0] !== 32'd21) $display("FAIL bp_beat7 got v=%b d=%0d exp v=1 d=21", a_ov[0], a_od[31:0]);
    else n_pass++;
    tick();
    n_total++; if (a_ov[0] !== 1'b0) $display("FAIL bp_drained got=%b exp=0", a_ov[0]); else n_pass++;
  endtask

  // All four ports read address 9 together; port 1 then stalls alone.
  task automatic test_multiport();
    a_ry = 4'b1101; a_rv = 4'hF;
    for (int p = 0; p < 4; p++) a_addr[p*10 +: 10] = 10'd9;
    tick(); a_rv = 4'h0;
    tick();
    for (int p = 0; p < 4; p++) begin
      n_total++;
      if (a_ov[p] !== 1'b1 || a_od[p*32 +: 32] !== 32'd27)
        $display("FAIL mp_same_addr_p%0d got v=%b d=%0d exp v=1 d=27", p, a_ov[p], a_od[p*32 +: 32]);
      else n_pass++;
    end
    a_rv = 4'b1101;
    for (int p = 0; p < 4; p++) a_addr[p*10 +: 10] = 10'd10;
    #1;
    n_total++; if (a_rr !== 4'b1101) $display("FAIL mp_ready got=%b exp=1101", a_rr); else n_pass++;
    tick(); a_rv = 4'h0;
    tick();
    for (int p = 0; p < 4; p++) begin
      if (p != 1) begin
        n_total++;
        if (a_ov[p] !== 1'b1 || a_od[p*32 +: 32] !== 32'd30)
          $display("FAIL mp_indep_p%0d got v=%b d=%0d exp v=1 d=30", p, a_ov[p], a_od[p*32 +: 32]);
        else n_pass++;
      end
    end
    n_total++;
    if (a_ov[1] !== 1'b1 || a_od[63:32] !== 32'd27) $display("FAIL mp_stalled_p1 got v=%b d=%0d exp v=1 d=27", a_ov[1], a_od[63:32]);
    else n_pass++;
    a_ry = 4'hF;
    tick();
    n_total++; if (a_ov !== 4'h0) $display("FAIL mp_drained got=%b exp=0000", a_ov); else n_pass++;
  endtask

  // DEPTH is 100: address 99 is the last word, 100 is past the end.
  task automatic test_bounds();
    a_ry = 4'hF; a_rv = 4'b1100;
    a_addr[20 +: 10] = 10'd100;
    a_addr[30 +: 10] = 10'd99;
    tick(); a_rv = 4'h0;
    tick();
    n_total++;
    if (a_ov[3] !== 1'b1 || a_od[96 +: 32] !== 32'd297 || a_oe[3] !== 1'b0)
      $display("FAIL bounds_last got v=%b d=%0d e=%b exp v=1 d=297 e=0", a_ov[3], a_od[96 +: 32], a_oe[3]);
    else n_pass++;
`ifdef GENERIC_ROM_MP_BOUNDS_CHECK_EN
    n_total++;
    if (a_ov[2] !== 1'b1 || a_od[64 +: 32] !== 32'd0 || a_oe[2] !== 1'b1)
      $display("FAIL bounds_over got v=%b d=%0d e=%b exp v=1 d=0 e=1", a_ov[2], a_od[64 +: 32], a_oe[2]);
    else n_pass++;
`else
    n_total++;
    if (a_ov[2] !== 1'b1 || a_oe[2] !== 1'b0)
      $display("FAIL bounds_over got v=%b e=%b exp v=1 e=0", a_ov[2], a_oe[2]);
    else n_pass++;
`endif
    tick();
  endtask

  // Reset with two beats in flight on port 0, plus a request during reset.
  task automatic test_reset_flight();
    bit seen = 1'b0;
    a_ry = 4'hE; a_rv = 4'b0001; a_addr[9:0] = 10'd1;
    tick(); a_addr[9:0] = 10'd2;
    tick();
    n_total++;
    if (a_ov[0] !== 1'b1 || a_od[31:0] !== 32'd3) $display("FAIL rf_inflight got v=%b d=%0d exp v=1 d=3", a_ov[0], a_od[31:0]);
    else n_pass++;
    rst = 1'b1; a_addr[9:0] = 10'd3;
    tick();
    n_total++;
    if (a_ov[0] !== 1'b0 || a_od[31:0] !== 32'd0 || a_rr[0] !== 1'b1)
      $display("FAIL rf_after_reset got v=%b d=%0d rdy=%b exp v=0 d=0 rdy=1", a_ov[0], a_od[31:0], a_rr[0]);
    else n_pass++;
    rst = 1'b0; a_rv = 4'h0; a_ry = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_ov[0]) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rf_stale_beat got=1 exp=0"); else n_pass++;
  endtask

  // Random valid/ready on every port of every latency variant.
  task automatic test_random();
    int unsigned q [8][$];
    int sent [8];
    int got  [8];
    int bad  [8];
    int cyc = 0;
    bit done = 1'b0;
    int unsigned e;
    for (int i = 0; i < 8; i++) begin sent[i] = 0; got[i] = 0; bad[i] = 0; end
    while (!done && cyc < 40000) begin
      for (int g = 0; g < RN; g++) begin
        for (int p = 0; p < 2; p++) begin
          r_rv[g][p] = (sent[g*2+p] < RND_N) && ($urandom_range(0, 1) == 1);
          r_addr[g][p*6 +: 6] = 6'($urandom_range(0, 63));
          r_ry[g][p] = ($urandom_range(0, 3) != 0);
        end
      end
      #1;
      for (int g = 0; g < RN; g++) begin
        for (int p = 0; p < 2; p++) begin
          if (r_ov[g][p] && r_ry[g][p]) begin
            if (q[g*2+p].size() == 0) bad[g*2+p]++;
            else begin
              e = q[g*2+p].pop_front();
              if (r_od[g][p*16 +: 16] !== 16'(e*3) || r_oe[g][p] !== 1'b0) bad[g*2+p]++;
            end
            got[g*2+p]++;
          end
          if (r_rv[g][p] && r_rr[g][p]) begin
            q[g*2+p].push_back(32'(r_addr[g][p*6 +: 6]));
            sent[g*2+p]++;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      done = 1'b1;
      for (int i = 0; i < 8; i++) if (got[i] < RND_N) done = 1'b0;
    end
    for (int g = 0; g < RN; g++) begin r_rv[g] = '0; r_ry[g] = '1; end
    n_total++; if (done !== 1'b1) $display("FAIL rnd_timeout got cycles=%0d exp done", cyc); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (bad[i] != 0) $display("FAIL rnd_data_rl%0d_p%0d got mismatches=%0d exp=0", i/2+1, i%2, bad[i]);
      else n_pass++;
      n_total++;
      if (got[i] != RND_N || sent[i] != RND_N)
        $display("FAIL rnd_count_rl%0d_p%0d got rsp=%0d req=%0d exp=%0d", i/2+1, i%2, got[i], sent[i], RND_N);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_multiport();
    test_bounds();
    test_reset_flight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
